// File: rtl/rx_phase_derotator.sv
// rx_phase_derotator: tracks the per-shot phase-cycling index and removes the TX phase from each I/Q sample.
// Optional build macro RX_DEROT_SAT_EN: saturate the negation of the most-negative sample value.
module rx_phase_derotator #(
    parameter int DATA_W   = 16,
    parameter int N_PHASES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*N_PHASES-1:0]    phase_list,
    input  logic                     shot_start,
    input  logic [15:0]              acq_len,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_i,
    input  logic signed [DATA_W-1:0] s_q,
    output logic                     m_valid,
    output logic signed [DATA_W-1:0] m_i,
    output logic signed [DATA_W-1:0] m_q,
    output logic [1:0]               m_phase,
    output logic [1:0]               shot_idx,
    output logic                     shot_done
);

    typedef enum logic [1:0] {IDLE, ACQ, DRAIN} state_t;

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};

    state_t                     state;
    logic [15:0]                cnt;
    logic [15:0]                len;
    logic [1:0]                 cur_phase;
    logic                       first_shot;
    logic                       drain_second;
    logic [1:0]                 next_idx;
    logic [1:0]                 next_phase;
    logic                       accept;
    logic                       s1_valid;
    logic signed [DATA_W-1:0]   s1_i;
    logic signed [DATA_W-1:0]   s1_q;
    logic [1:0]                 s1_phase;
    logic signed [DATA_W-1:0]   rot_i;
    logic signed [DATA_W-1:0]   rot_q;

    function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] x);
`ifdef RX_DEROT_SAT_EN
        neg = (x == MIN_VAL) ? MAX_VAL : -x;
`else
        neg = -x;
`endif
    endfunction

    always_comb begin
        next_idx = 2'd0;
        if (!first_shot && shot_idx != 2'(N_PHASES-1))
            next_idx = shot_idx + 2'd1;
    end

    // Entry 0 sits in the most-significant field of the packed list.
    always_comb begin
        next_phase = 2'd0;
        for (int k = 0; k < N_PHASES; k++)
            if (next_idx == 2'(k))
                next_phase = phase_list[2*(N_PHASES-1-k) +: 2];
    end

    // A sample arriving with shot_start belongs to the new shot.
    always_comb begin
        if (shot_start)
            accept = s_valid && (acq_len != 16'd0);
        else
            accept = s_valid && (state == ACQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            len          <= 16'd0;
            cur_phase    <= 2'd0;
            first_shot   <= 1'b1;
            drain_second <= 1'b0;
            shot_idx     <= 2'd0;
            shot_done    <= 1'b0;
        end else begin
            shot_done <= 1'b0;
            if (shot_start) begin
                shot_idx     <= next_idx;
                first_shot   <= 1'b0;
                cur_phase    <= next_phase;
                len          <= acq_len;
                drain_second <= 1'b0;
                cnt          <= accept ? 16'd1 : 16'd0;
                if (acq_len == 16'd0 || (accept && acq_len == 16'd1))
                    state <= DRAIN;
                else
                    state <= ACQ;
            end else begin
                case (state)
                    IDLE: ;
                    ACQ: begin
                        if (s_valid) begin
                            cnt <= cnt + 16'd1;
                            if (cnt + 16'd1 == len) begin
                                state        <= DRAIN;
                                drain_second <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        // Second drain cycle lines up with the last sample leaving stage 2.
                        if (!drain_second) begin
                            drain_second <= 1'b1;
                            shot_done    <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rot_i = s1_i;
        rot_q = s1_q;
        case (s1_phase)
            2'd1: begin rot_i = s1_q;      rot_q = neg(s1_i); end
            2'd2: begin rot_i = neg(s1_i); rot_q = neg(s1_q); end
            2'd3: begin rot_i = neg(s1_q); rot_q = s1_i;      end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_phase <= 2'd0;
            m_valid  <= 1'b0;
            m_i      <= '0;
            m_q      <= '0;
            m_phase  <= 2'd0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_i     <= s_i;
                s1_q     <= s_q;
                s1_phase <= shot_start ? next_phase : cur_phase;
            end
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_i     <= rot_i;
                m_q     <= rot_q;
                m_phase <= s1_phase;
            end
        end
    end

endmodule

// File: tb/tb_rx_phase_derotator.sv
// Directed testbench for rx_phase_derotator: phase cycling, gating, abort, extremes and reset.
module tb_rx_phase_derotator;

    localparam int DATA_W   = 16;
    localparam int N_PHASES = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [2*N_PHASES-1:0]    phase_list;
    logic                     shot_start;
    logic [15:0]              acq_len;
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_i;
    logic signed [DATA_W-1:0] s_q;
    logic                     m_valid;
    logic signed [DATA_W-1:0] m_i;
    logic signed [DATA_W-1:0] m_q;
    logic [1:0]               m_phase;
    logic [1:0]               shot_idx;
    logic                     shot_done;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic [1:0]         ph;
        int                 cyc;
    } rec_t;

    rec_t out_q[$];
    rec_t exp_q[$];
    int   done_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    rx_phase_derotator #(.DATA_W(DATA_W), .N_PHASES(N_PHASES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_list (phase_list),
        .shot_start (shot_start),
        .acq_len    (acq_len),
        .s_valid    (s_valid),
        .s_i        (s_i),
        .s_q        (s_q),
        .m_valid    (m_valid),
        .m_i        (m_i),
        .m_q        (m_q),
        .m_phase    (m_phase),
        .shot_idx   (shot_idx),
        .shot_done  (shot_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output beat and shot_done pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (m_valid === 1'b1) out_q.push_back('{m_i, m_q, m_phase, cyc});
        if (shot_done === 1'b1) done_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ss, input logic sv, input int i, input int q);
        shot_start = ss;
        s_valid    = sv;
        s_i        = 16'(i);
        s_q        = 16'(q);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic expect_out(input int i, input int q, input int ph);
        exp_q.push_back('{16'(i), 16'(q), 2'(ph), cyc + 2});
    endtask

    task automatic clear_logs();
        out_q.delete();
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        phase_list = 6'b00_01_10;
        acq_len    = 16'd0;
        shot_start = 1'b0;
        s_valid    = 1'b0;
        s_i        = '0;
        s_q        = '0;
        #2;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); else passed++;
        checks++; if (m_i !== 16'sd0) $display("[TB] FAIL reset_m_i: got %0d expected 0", m_i); else passed++;
        checks++; if (m_q !== 16'sd0) $display("[TB] FAIL reset_m_q: got %0d expected 0", m_q); else passed++;
        checks++; if (m_phase !== 2'd0) $display("[TB] FAIL reset_m_phase: got %0d expected 0", m_phase); else passed++;
        checks++; if (shot_idx !== 2'd0) $display("[TB] FAIL reset_shot_idx: got %0d expected 0", shot_idx); else passed++;
        checks++; if (shot_done !== 1'b0) $display("[TB] FAIL reset_shot_done: got %b expected 0", shot_done); else passed++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_first_shot();
        clear_logs();
        phase_list = 6'b00_01_10;
        acq_len    = 16'd4;
        drive(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            expect_out(100, 20, 0);
            drive(1'b0, 1'b1, 100, 20);
        end
        idle(4);
        checks++;
        if (out_q.size() != exp_q.size()) $display("[TB] FAIL first_count: got %0d outputs expected %0d", out_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[k]) if (k < out_q.size()) begin
            checks++;
            if (out_q[k] !== exp_q[k])
                $display("[TB] FAIL first_out%0d: got (%0d,%0d) ph%0d cyc%0d expected (%0d,%0d) ph%0d cyc%0d", k,
                         out_q[k].i, out_q[k].q, out_q[k].ph, out_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].ph, exp_q[k].cyc);
            else passed++;
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_q[$].cyc)
            $display("[TB] FAIL first_done: got %0d pulses expected 1 at cyc %0d", done_q.size(), exp_q[$].cyc);
        else passed++;
        checks++; if (shot_idx !== 2'd0) $display("[TB] FAIL first_idx: got %0d expected 0", shot_idx); else passed++;
    endtask

    task automatic test_phase_cycle();
        int ei [4] = '{100, 20, -100, 100};
        int eq [4] = '{20, -100, -20, 20};
        int ep [4] = '{0, 1, 2, 0};
        do_reset();
        phase_list = 6'b00_01_10;
        acq_len    = 16'd2;
        for (int s = 0; s < 4; s++) begin
            clear_logs();
            drive(1'b1, 1'b0, 0, 0);
            for (int k = 0; k < 2; k++) begin
                expect_out(ei[s], eq[s], ep[s]);
                drive(1'b0, 1'b1, 100, 20);
            end
            idle(4);
            checks++;
            if (out_q.size() != 2) $display("[TB] FAIL cycle%0d_count: got %0d outputs expected 2", s, out_q.size());
            else passed++;
            foreach (exp_q[k]) if (k < out_q.size()) begin
                checks++;
                if (out_q[k] !== exp_q[k])
                    $display("[TB] FAIL cycle%0d_out%0d: got (%0d,%0d) ph%0d expected (%0d,%0d) ph%0d", s, k,
                             out_q[k].i, out_q[k].q, out_q[k].ph, exp_q[k].i, exp_q[k].q, exp_q[k].ph);
                else passed++;
            end
            checks++;
            if (shot_idx !== 2'(s % 3)) $display("[TB] FAIL cycle%0d_idx: got %0d expected %0d", s, shot_idx, s % 3);
            else passed++;
            checks++;
            if (done_q.size() != 1) $display("[TB] FAIL cycle%0d_done: got %0d pulses expected 1", s, done_q.size());
            else passed++;
        end
    endtask

    task automatic test_code3_list_change();
        clear_logs();
        phase_list = 6'b11_11_11;
        acq_len    = 16'd4;
        drive(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) phase_list = 6'b00_00_00;
            expect_out(-(20 + k), 100 + k, 3);
            drive(1'b0, 1'b1, 100 + k, 20 + k);
        end
        idle(4);
        checks++;
        if (out_q.size() != 4) $display("[TB] FAIL code3_count: got %0d outputs expected 4", out_q.size());
        else passed++;
        foreach (exp_q[k]) if (k < out_q.size()) begin
            checks++;
            if (out_q[k] !== exp_q[k])
                $display("[TB] FAIL code3_out%0d: got (%0d,%0d) ph%0d expected (%0d,%0d) ph%0d", k,
                         out_q[k].i, out_q[k].q, out_q[k].ph, exp_q[k].i, exp_q[k].q, exp_q[k].ph);
            else passed++;
        end
        clear_logs();
        acq_len = 16'd1;
        drive(1'b1, 1'b0, 0, 0);
        expect_out(100, 20, 0);
        drive(1'b0, 1'b1, 100, 20);
        idle(4);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp_q[0])
            $display("[TB] FAIL code0_next: got %0d outputs first (%0d,%0d) ph%0d expected (100,20) ph0",
                     out_q.size(), out_q.size() > 0 ? out_q[0].i : 16'sd0, out_q.size() > 0 ? out_q[0].q : 16'sd0,
                     out_q.size() > 0 ? out_q[0].ph : 2'd0);
        else passed++;
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_q[0].cyc)
            $display("[TB] FAIL code0_done: got %0d pulses expected 1", done_q.size());
        else passed++;
    endtask

    task automatic test_gating();
        int c_start;
        clear_logs();
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 7, 7);
        idle(3);
        checks++;
        if (out_q.size() != 0) $display("[TB] FAIL idle_drop: got %0d outputs expected 0", out_q.size());
        else passed++;
        clear_logs();
        acq_len = 16'd2;
        drive(1'b1, 1'b0, 0, 0);
        expect_out(1, 2, 0);
        drive(1'b0, 1'b1, 1, 2);
        expect_out(3, 4, 0);
        drive(1'b0, 1'b1, 3, 4);
        drive(1'b0, 1'b1, 5, 6);
        drive(1'b0, 1'b1, 7, 8);
        idle(4);
        checks++;
        if (out_q.size() != 2) $display("[TB] FAIL overrun_count: got %0d outputs expected 2", out_q.size());
        else passed++;
        foreach (exp_q[k]) if (k < out_q.size()) begin
            checks++;
            if (out_q[k] !== exp_q[k])
                $display("[TB] FAIL overrun_out%0d: got (%0d,%0d) cyc%0d expected (%0d,%0d) cyc%0d", k,
                         out_q[k].i, out_q[k].q, out_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].cyc);
            else passed++;
        end
        clear_logs();
        acq_len = 16'd0;
        c_start = cyc;
        drive(1'b1, 1'b1, 9, 9);
        idle(5);
        checks++;
        if (out_q.size() != 0) $display("[TB] FAIL zero_len_out: got %0d outputs expected 0", out_q.size());
        else passed++;
        checks++;
        if (done_q.size() != 1 || done_q[0] != c_start + 2)
            $display("[TB] FAIL zero_len_done: got %0d pulses expected 1 at cyc %0d", done_q.size(), c_start + 2);
        else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        clear_logs();
        phase_list = 6'b00_01_10;
        acq_len    = 16'd5;
        drive(1'b1, 1'b0, 0, 0);
        expect_out(10, 1, 0);
        drive(1'b0, 1'b1, 10, 1);
        expect_out(11, 2, 0);
        drive(1'b0, 1'b1, 11, 2);
        expect_out(60, -50, 1);
        drive(1'b1, 1'b1, 50, 60);
        for (int k = 1; k < 5; k++) begin
            expect_out(60 + k, -(50 + k), 1);
            drive(1'b0, 1'b1, 50 + k, 60 + k);
        end
        drive(1'b0, 1'b1, 99, 99);
        idle(4);
        checks++;
        if (out_q.size() != 7) $display("[TB] FAIL abort_count: got %0d outputs expected 7", out_q.size());
        else passed++;
        foreach (exp_q[k]) if (k < out_q.size()) begin
            checks++;
            if (out_q[k] !== exp_q[k])
                $display("[TB] FAIL abort_out%0d: got (%0d,%0d) ph%0d cyc%0d expected (%0d,%0d) ph%0d cyc%0d", k,
                         out_q[k].i, out_q[k].q, out_q[k].ph, out_q[k].cyc, exp_q[k].i, exp_q[k].q, exp_q[k].ph, exp_q[k].cyc);
            else passed++;
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_q[$].cyc)
            $display("[TB] FAIL abort_done: got %0d pulses expected 1 at cyc %0d", done_q.size(), exp_q[$].cyc);
        else passed++;
        checks++; if (shot_idx !== 2'd1) $display("[TB] FAIL abort_idx: got %0d expected 1", shot_idx); else passed++;
    endtask

    task automatic test_extreme_and_reset();
        int exp_i;
`ifdef RX_DEROT_SAT_EN
        exp_i = 32767;
`else
        exp_i = -32768;
`endif
        clear_logs();
        phase_list = 6'b10_10_10;
        acq_len    = 16'd1;
        drive(1'b1, 1'b0, 0, 0);
        expect_out(exp_i, -5, 2);
        drive(1'b0, 1'b1, -32768, 5);
        idle(4);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp_q[0])
            $display("[TB] FAIL extreme_neg: got %0d outputs first (%0d,%0d) expected (%0d,-5)", out_q.size(),
                     out_q.size() > 0 ? out_q[0].i : 16'sd0, out_q.size() > 0 ? out_q[0].q : 16'sd0, exp_i);
        else passed++;
        acq_len = 16'd3;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1, 1);
        drive(1'b0, 1'b1, 2, 2);
        checks++; if (m_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b expected 1", m_valid); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL async_reset_valid: got %b expected 0", m_valid); else passed++;
        clear_logs();
        idle(2);
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (done_q.size() != 0 || out_q.size() != 0)
            $display("[TB] FAIL reset_flush: got %0d pulses %0d outputs expected 0 0", done_q.size(), out_q.size());
        else passed++;
        clear_logs();
        phase_list = 6'b01_10_11;
        acq_len    = 16'd1;
        drive(1'b1, 1'b0, 0, 0);
        expect_out(20, -100, 1);
        drive(1'b0, 1'b1, 100, 20);
        idle(4);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp_q[0])
            $display("[TB] FAIL post_reset_out: got %0d outputs first (%0d,%0d) ph%0d expected (20,-100) ph1", out_q.size(),
                     out_q.size() > 0 ? out_q[0].i : 16'sd0, out_q.size() > 0 ? out_q[0].q : 16'sd0,
                     out_q.size() > 0 ? out_q[0].ph : 2'd0);
        else passed++;
        checks++; if (shot_idx !== 2'd0) $display("[TB] FAIL post_reset_idx: got %0d expected 0", shot_idx); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_phase_cycle();
        test_code3_list_change();
        test_gating();
        test_abort();
        test_extreme_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rx_phase_derotator.md
# rx_phase_derotator

Receive-side counterpart to the transmit phase selection logic. Tracks the phase-cycling position shot by shot, using the same packed 2-bit phase list the TX path uses. Undoes the transmit phase on each incoming I/Q sample so that successive shots can be summed coherently downstream. It sits between the ADC decimation output and the averaging buffer.

## Interface
- `DATA_W`, 16, width of signed I and Q samples.
- `N_PHASES`, 3, number of entries in the phase list (1..4).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `phase_list` in 2*N_PHASES: packed phase codes (0=0°, 1=90°, 2=180°, 3=270°). Entry 0 is the most-significant field.
- `shot_start` in 1: one-cycle pulse that begins a shot.
- `acq_len` in 16: samples to accept per shot; latched on `shot_start`.
- `s_valid` in 1: input sample strobe; there is no backpressure.
- `s_i`, `s_q` in DATA_W: signed input sample.
- `m_valid` out 1: output sample strobe.
- `m_i`, `m_q` out DATA_W: signed derotated sample.
- `m_phase` out 2: phase code applied to the current output sample.
- `shot_idx` out 2: phase-list index of the current or last shot.
- `shot_done` out 1: one-cycle pulse when a shot's last sample leaves the pipeline, or when a shot ends with zero samples.

## Operation
- **FSM states:**
  - IDLE → ACQ on `shot_start`.
  - ACQ → DRAIN when the accepted-sample count reaches the latched `acq_len`.
  - DRAIN → IDLE after 2 cycles, asserting `shot_done` in the exit cycle.
  - When `acq_len` = 0: ACQ → DRAIN in the same cycle it is entered; `shot_done` follows 2 cycles later and no samples are accepted.
- **Phase index:**
  - The first `shot_start` after reset uses index 0.
  - Each later `shot_start` advances the index by 1, wrapping from N_PHASES-1 to 0.
  - The phase code comes from field `N_PHASES-1-idx` of `phase_list`, sampled on `shot_start`.
  - Changes to `phase_list` mid-shot have no effect until the next shot.
- **Sample acceptance:** samples are accepted only in ACQ with `s_valid`=1. Samples arriving in IDLE or DRAIN are dropped.
- **Derotation** (multiply by e^-jφ):
  - code 0 → (I, Q)
  - code 1 → (Q, −I)
  - code 2 → (−I, −Q)
  - code 3 → (−Q, I)
- **`shot_start` during ACQ or DRAIN:**
  - Aborts the current shot with no `shot_done`.
  - Advances the index, relatches phase and `acq_len`, and clears the sample counter.
  - Samples already in the pipeline still emerge, tagged with their old `m_phase`.
- **Same-cycle `shot_start` and `s_valid`:** the sample belongs to the new shot, uses the new phase, and counts as sample 1.

## Timing
- Latency is 2 cycles from the accepting `s_valid` edge to `m_valid`.
  - Stage 1 registers the sample and phase.
  - Stage 2 registers the derotated result.
- Throughput is 1 sample per clock.
- Reset values:
  - `m_valid`=0, `m_i`=0, `m_q`=0, `m_phase`=0, `shot_idx`=0, `shot_done`=0.
  - FSM in IDLE, sample counter at 0, and the internal "first shot" flag set.
- Reset asserted mid-shot clears the pipeline immediately: `m_valid` drops asynchronously and no `shot_done` is produced.
- `shot_done` coincides with the last `m_valid` of the shot.
- `shot_idx` updates in the cycle after `shot_start`.

## Configuration
- Macro: `RX_DEROT_SAT_EN`.
- **Defined:** negating −2^(DATA_W−1) yields +2^(DATA_W−1)−1 (saturating).
- **Undefined:** plain two's-complement negate, so −2^(DATA_W−1) stays −2^(DATA_W−1).
- All other behaviour is identical in both builds.

## Test plan
- **Reset and first shot.** Set `phase_list`={0,1,2} and `acq_len`=4, pulse `shot_start`, then drive 4 samples of (100, 20).
  - Required: 4 outputs of (100, 20) with `m_phase`=0, each 2 cycles after its input.
  - Required: `shot_done` on the 4th output; `shot_idx`=0.
- **Phase cycling and wrap.** Run 4 consecutive shots with input (100, 20).
  - Required outputs per shot: (100, 20), then (20, −100), then (−100, −20), then (100, 20).
  - Required: `shot_idx` sequence 0, 1, 2, 0.
- **Code 3 and list change mid-shot.** Set `phase_list`={3,3,3} and start a shot. Change the list to {0,0,0} mid-shot.
  - Required: all samples in that shot output (−Q, I).
  - Required: the next shot uses code 0.
- **Gating.** Drive `s_valid` in IDLE, then after the `acq_len` count is reached.
  - Required: no `m_valid` for those samples.
  - Required: `acq_len`=0 gives `shot_done` with no `m_valid`.
- **Abort.** Pulse `shot_start` after 2 of 5 samples.
  - Required: no `shot_done` for the aborted shot.
  - Required: the new shot uses the next index and accepts 5 fresh samples.
  - Required: the same-cycle sample counts as sample 1.
- **Extreme values and reset.** Input I=−32768 with code 2.
  - Required: output +32767 with `RX_DEROT_SAT_EN` defined, −32768 without.
  - Assert `rst_n` mid-pipeline: `m_valid`=0 immediately, and the next shot uses index 0.
